// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter for a shared SPI byte engine.
// Round-robin frame arbitration, chip-select setup and gap timing, idle-timeout revocation.
module spi_bus_arbiter #(
    parameter int CS_SETUP     = 2,
    parameter int CS_GAP       = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] REQ,
    input  logic [1:0] BEGIN,
    input  logic [7:0] SEND_DATA0,
    input  logic [7:0] SEND_DATA1,
    output logic [1:0] GNT,
    output logic [1:0] END,
    output logic [7:0] RX_DATA,
    output logic [1:0] ABORT,
    output logic [1:0] CS_N,
    output logic       SPI_BEGIN,
    output logic [7:0] SPI_SEND_DATA,
    input  logic       SPI_END,
    input  logic [7:0] SPI_RX_DATA
);

    localparam int MAX_A = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int MAX_B = (MAX_A > IDLE_TIMEOUT) ? MAX_A : IDLE_TIMEOUT;
    localparam int MAXC  = (MAX_B > 1) ? MAX_B : 1;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'((CS_SETUP > 1) ? CS_SETUP - 1 : 0);
    localparam logic [CW-1:0] IDLE_LAST  = CW'((IDLE_TIMEOUT > 1) ? IDLE_TIMEOUT - 1 : 0);
    // The IDLE cycle that samples requests is itself chip-select-high, so the
    // GAP state lasts one cycle less than the required minimum gap.
    localparam logic [CW-1:0] GAP_LAST   = CW'((CS_GAP > 2) ? CS_GAP - 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        BUSY,
        GAP
    } state_t;

    localparam state_t REL_STATE = (CS_GAP > 1) ? GAP : IDLE;

    state_t        state;
    logic          win;
    logic          last;
    logic [CW-1:0] cnt;

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            win           <= 1'b0;
            last          <= 1'b1;
            cnt           <= '0;
            GNT           <= '0;
            END           <= '0;
            ABORT         <= '0;
            CS_N          <= '1;
            SPI_BEGIN     <= 1'b0;
            SPI_SEND_DATA <= '0;
            RX_DATA       <= '0;
        end else begin
            END       <= '0;
            ABORT     <= '0;
            SPI_BEGIN <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (REQ != 2'b00) begin
                        if (REQ == 2'b11) begin
                            win  <= ~last;
                            CS_N <= last ? 2'b10 : 2'b01;
                        end else begin
                            win  <= REQ[1];
                            CS_N <= REQ[1] ? 2'b01 : 2'b10;
                        end
                        cnt   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (!REQ[win]) begin
                        CS_N  <= '1;
                        cnt   <= '0;
                        state <= REL_STATE;
                    end else if (cnt == SETUP_LAST) begin
                        GNT   <= win ? 2'b10 : 2'b01;
                        cnt   <= '0;
                        state <= ACTIVE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ACTIVE: begin
                    if (!REQ[win] || (!BEGIN[win] && cnt == IDLE_LAST)) begin
                        if (REQ[win]) begin
                            ABORT[win] <= 1'b1;
                        end
                        GNT   <= '0;
                        CS_N  <= '1;
                        last  <= win;
                        cnt   <= '0;
                        state <= REL_STATE;
                    end else if (BEGIN[win]) begin
                        SPI_SEND_DATA <= win ? SEND_DATA1 : SEND_DATA0;
                        SPI_BEGIN     <= 1'b1;
                        cnt           <= '0;
                        state         <= BUSY;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BUSY: begin
                    if (SPI_END) begin
                        END[win] <= 1'b1;
                        RX_DATA  <= SPI_RX_DATA;
                        state    <= ACTIVE;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 The block SHALL have parameter CS_SETUP, default 2: cycles from chip-select assertion to grant.
REQ-002 The block SHALL have parameter CS_GAP, default 4: minimum chip-select-high cycles between frames.
REQ-003 The block SHALL have parameter IDLE_TIMEOUT, default 1024: cycles a granted frame may sit idle before it is revoked.
REQ-004 The block SHALL have port CLK, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port REQ, input, 2 bits: per-requester frame request, held high for the whole frame.
REQ-007 The block SHALL have port BEGIN, input, 2 bits: per-requester one-cycle byte-start pulse.
REQ-008 The block SHALL have ports SEND_DATA0 and SEND_DATA1, input, 8 bits each: byte to transmit for each requester.
REQ-009 The block SHALL have port GNT, output, 2 bits: one-hot grant; requester may pulse BEGIN only while its bit is high.
REQ-010 The block SHALL have port END, output, 2 bits: per-requester one-cycle byte-complete pulse.
REQ-011 The block SHALL have port RX_DATA, output, 8 bits: received byte, valid in the END pulse cycle.
REQ-012 The block SHALL have port ABORT, output, 2 bits: one-cycle pulse when a frame is revoked by timeout.
REQ-013 The block SHALL have port CS_N, output, 2 bits: active-low chip select per device (bit i is device of requester i).
REQ-014 The block SHALL have port SPI_BEGIN, output, 1 bit: begin pulse to the shared SPI byte engine.
REQ-015 The block SHALL have port SPI_SEND_DATA, output, 8 bits: byte to the SPI engine.
REQ-016 The block SHALL have port SPI_END, input, 1 bit: byte-done pulse from the SPI engine.
REQ-017 The block SHALL have port SPI_RX_DATA, input, 8 bits: received byte from the SPI engine, valid with SPI_END.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, ACTIVE, BUSY and GAP, with winner index W and a last-served pointer LAST.
REQ-019 In IDLE with any REQ high, the FSM SHALL pick W by round-robin: on both high, choose the one not equal to LAST; on one high, choose it. It SHALL then go to SETUP with CS_N[W]=0 at the next edge.
REQ-020 SETUP SHALL count CS_SETUP cycles, then go to ACTIVE, with GNT[W] high from the first ACTIVE cycle.
REQ-021 If REQ[W] drops during SETUP, the FSM SHALL go to GAP without granting.
REQ-022 In ACTIVE, BEGIN[W] high in cycle k SHALL latch SEND_DATA_W, drive SPI_BEGIN high for exactly cycle k+1, and enter BUSY.
REQ-023 In BUSY, GNT[W] SHALL stay high and further BEGIN pulses SHALL be ignored (no second SPI_BEGIN).
REQ-024 SPI_END high in cycle m SHALL produce END[W] high and RX_DATA=SPI_RX_DATA in cycle m+1, then return to ACTIVE.
REQ-025 RX_DATA SHALL hold its value between END pulses.
REQ-026 BEGIN from the non-granted requester SHALL always be ignored.
REQ-027 SPI_END outside BUSY SHALL be ignored.
REQ-028 When REQ[W] drops in ACTIVE, the next edge SHALL deassert GNT, set CS_N to 11, set LAST=W, and enter GAP.
REQ-029 When REQ[W] drops in BUSY, the byte SHALL complete (END[W] delivered), then release as in REQ-028.
REQ-030 An idle counter SHALL count ACTIVE cycles with no BEGIN[W] and SHALL reset on BEGIN[W].
REQ-031 When the idle counter reaches IDLE_TIMEOUT, the block SHALL pulse ABORT[W] for 1 cycle and release as in REQ-028.
REQ-032 GAP SHALL hold CS_N=11 and GNT=00 for CS_GAP cycles, then go to IDLE; requests SHALL be sampled only in IDLE.
REQ-033 At most one CS_N bit SHALL be low and at most one GNT bit high at any time.
REQ-034 GNT[i] SHALL imply CS_N[i]=0.
REQ-035 Counters SHALL be wide enough for their parameter, with no wrap-around before terminal count.
REQ-036 SPI_SEND_DATA SHALL hold the latched byte until the next latch.

Reset
REQ-037 While RST is high at a clock edge, the FSM SHALL go to IDLE and LAST SHALL be set to 1, so requester 0 wins the first tie.
REQ-038 While RST is high at a clock edge, the outputs SHALL be GNT=00, END=00, ABORT=00, CS_N=11, SPI_BEGIN=0, SPI_SEND_DATA=0x00, RX_DATA=0x00, and all counters SHALL clear.
REQ-039 RST asserted mid-frame, including in BUSY, SHALL abandon the frame immediately with no END or ABORT pulse; a late SPI_END SHALL be ignored.

Verification
REQ-040 Single frame: REQ=01 at cycle 0 -> CS_N=10 at cycle 1, GNT=01 at cycle 3; BEGIN0 with 0xA8 -> SPI_BEGIN one cycle, SPI_SEND_DATA=0xA8; SPI_END with 0x5C -> END=01, RX_DATA=0x5C.
REQ-041 Tie after reset: REQ=11 -> requester 0 granted; after it releases and GAP (4 cycles), requester 1 granted; next tie -> requester 0.
REQ-042 Release during byte: REQ0 drops in BUSY -> GNT held until END0, then CS_N=11 for exactly 4 cycles before any new CS_N low.
REQ-043 Timeout: granted, no BEGIN for 1024 cycles -> ABORT=01 single pulse, GNT=00, CS_N=11; requester 1 pending -> granted after GAP.
REQ-044 Illegal stimulus: BEGIN1 while requester 0 granted, second BEGIN0 in BUSY, stray SPI_END in ACTIVE -> no SPI_BEGIN, no END, state unchanged.
REQ-045 Reset in BUSY: RST high one cycle -> next cycle all outputs at reset values; a later SPI_END produces no END.
